// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue for the Tomasulo core.
// Allocates one tag per issued instruction, captures ALU/LSB writebacks, retires the head
// entry through registered commit/rollback pulses and flushes on a branch mispredict.
// Optional feature: define ROB_QUERY_BYPASS_EN to forward same-cycle writebacks to the
// operand query ports.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE    = 16,
    parameter int unsigned ROB_POS_WID = $clog2(ROB_SIZE),
    parameter int unsigned REG_POS_WID = 5,
    parameter int unsigned DATA_WID    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic                   issue,
    input  logic [1:0]             issue_type,
    input  logic [REG_POS_WID-1:0] issue_rd,
    input  logic [DATA_WID-1:0]    issue_pc,
    input  logic                   issue_pred_jmp,
    output logic [ROB_POS_WID-1:0] alloc_pos,
    output logic                   rob_full,
    input  logic                   alu_result,
    input  logic [ROB_POS_WID-1:0] alu_rob_pos,
    input  logic [DATA_WID-1:0]    alu_val,
    input  logic                   alu_real_jmp,
    input  logic [DATA_WID-1:0]    alu_jmp_pc,
    input  logic                   lsb_result,
    input  logic [ROB_POS_WID-1:0] lsb_rob_pos,
    input  logic [DATA_WID-1:0]    lsb_val,
    input  logic [ROB_POS_WID-1:0] q_pos1,
    input  logic [ROB_POS_WID-1:0] q_pos2,
    output logic                   q_rdy1,
    output logic                   q_rdy2,
    output logic [DATA_WID-1:0]    q_val1,
    output logic [DATA_WID-1:0]    q_val2,
    output logic                   commit,
    output logic [REG_POS_WID-1:0] commit_rd,
    output logic [DATA_WID-1:0]    commit_val,
    output logic [ROB_POS_WID-1:0] commit_rob_pos,
    output logic                   commit_store,
    output logic                   rollback,
    output logic [DATA_WID-1:0]    rollback_pc
);

    localparam int unsigned CntW = ROB_POS_WID + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(ROB_SIZE);

    typedef enum logic [1:0] {
        RobReg  = 2'd0,
        RobBr   = 2'd1,
        RobSt   = 2'd2,
        RobRsvd = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic                   busy;
        logic                   ready;
        rob_type_e              kind;
        logic [REG_POS_WID-1:0] rd;
        logic [DATA_WID-1:0]    val;
        logic [DATA_WID-1:0]    pc;
        logic                   pred_jmp;
        logic                   real_jmp;
        logic [DATA_WID-1:0]    jmp_pc;
    } entry_t;

    entry_t                 ent_q [ROB_SIZE];
    entry_t                 ent_d [ROB_SIZE];
    logic [ROB_POS_WID-1:0] head_q, head_d;
    logic [ROB_POS_WID-1:0] tail_q, tail_d;
    logic [CntW-1:0]        count_q, count_d;

    logic                   commit_q, commit_d;
    logic [REG_POS_WID-1:0] commit_rd_q, commit_rd_d;
    logic [DATA_WID-1:0]    commit_val_q, commit_val_d;
    logic [ROB_POS_WID-1:0] commit_rob_pos_q, commit_rob_pos_d;
    logic                   commit_store_q, commit_store_d;
    logic                   rollback_q, rollback_d;
    logic [DATA_WID-1:0]    rollback_pc_q, rollback_pc_d;

    logic accept;
    logic do_issue;
    logic do_retire;
    logic mispredict;

    assign rob_full       = (count_q == FullCnt);
    assign alloc_pos      = tail_q;
    assign commit         = commit_q;
    assign commit_rd      = commit_rd_q;
    assign commit_val     = commit_val_q;
    assign commit_rob_pos = commit_rob_pos_q;
    assign commit_store   = commit_store_q;
    assign rollback       = rollback_q;
    assign rollback_pc    = rollback_pc_q;

    // Next state: writebacks, then head retire, then tail allocate, then mispredict flush.
    always_comb begin
        ent_d            = ent_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        commit_d         = 1'b0;
        commit_store_d   = 1'b0;
        rollback_d       = 1'b0;
        commit_rd_d      = commit_rd_q;
        commit_val_d     = commit_val_q;
        commit_rob_pos_d = commit_rob_pos_q;
        rollback_pc_d    = rollback_pc_q;
        do_issue         = 1'b0;
        do_retire        = 1'b0;
        mispredict       = 1'b0;
        // Traffic seen while a rollback pulse is out belongs to squashed instructions.
        accept           = rdy && !rollback_q;

        if (rdy) begin
            // LSB first so that an ALU writeback to the same tag overrides it.
            if (accept && lsb_result && ent_q[lsb_rob_pos].busy) begin
                ent_d[lsb_rob_pos].ready = 1'b1;
                ent_d[lsb_rob_pos].val   = lsb_val;
            end
            if (accept && alu_result && ent_q[alu_rob_pos].busy) begin
                ent_d[alu_rob_pos].ready    = 1'b1;
                ent_d[alu_rob_pos].val      = alu_val;
                ent_d[alu_rob_pos].real_jmp = alu_real_jmp;
                ent_d[alu_rob_pos].jmp_pc   = alu_jmp_pc;
            end

            if (count_q != '0 && ent_q[head_q].busy && ent_q[head_q].ready) begin
                do_retire        = 1'b1;
                commit_d         = 1'b1;
                commit_val_d     = ent_q[head_q].val;
                commit_rob_pos_d = head_q;
                commit_rd_d      = ent_q[head_q].rd;
                if (ent_q[head_q].kind == RobSt) begin
                    commit_store_d = 1'b1;
                    commit_rd_d    = '0;
                end
                if (ent_q[head_q].kind == RobBr) begin
                    commit_rd_d = '0;
                    if (ent_q[head_q].real_jmp != ent_q[head_q].pred_jmp) begin
                        mispredict    = 1'b1;
                        rollback_d    = 1'b1;
                        rollback_pc_d = ent_q[head_q].real_jmp ? ent_q[head_q].jmp_pc
                                                               : ent_q[head_q].pc + DATA_WID'(4);
                    end
                end
                ent_d[head_q] = '0;
                head_d        = head_q + ROB_POS_WID'(1);
            end

            if (accept && issue && !rob_full) begin
                do_issue      = 1'b1;
                ent_d[tail_q] = '{
                    busy:     1'b1,
                    ready:    1'b0,
                    kind:     rob_type_e'(issue_type),
                    rd:       issue_rd,
                    val:      '0,
                    pc:       issue_pc,
                    pred_jmp: issue_pred_jmp,
                    real_jmp: 1'b0,
                    jmp_pc:   '0
                };
                tail_d = tail_q + ROB_POS_WID'(1);
            end

            count_d = count_q + CntW'(do_issue) - CntW'(do_retire);

            if (mispredict) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                for (int i = 0; i < int'(ROB_SIZE); i++) begin
                    ent_d[i].busy  = 1'b0;
                    ent_d[i].ready = 1'b0;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                ent_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            commit_q         <= 1'b0;
            commit_rd_q      <= '0;
            commit_val_q     <= '0;
            commit_rob_pos_q <= '0;
            commit_store_q   <= 1'b0;
            rollback_q       <= 1'b0;
            rollback_pc_q    <= '0;
        end else begin
            ent_q            <= ent_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            commit_q         <= commit_d;
            commit_rd_q      <= commit_rd_d;
            commit_val_q     <= commit_val_d;
            commit_rob_pos_q <= commit_rob_pos_d;
            commit_store_q   <= commit_store_d;
            rollback_q       <= rollback_d;
            rollback_pc_q    <= rollback_pc_d;
        end
    end

    // Operand lookup: {ready, value}; non-busy entries read as zero.
    function automatic logic [DATA_WID:0] query(input logic [ROB_POS_WID-1:0] pos);
        logic [DATA_WID:0] r;
        r = '0;
        if (ent_q[pos].busy) begin
            r = {ent_q[pos].ready, ent_q[pos].val};
`ifdef ROB_QUERY_BYPASS_EN
            if (rdy && !rollback_q) begin
                if (alu_result && alu_rob_pos == pos) begin
                    r = {1'b1, alu_val};
                end else if (lsb_result && lsb_rob_pos == pos) begin
                    r = {1'b1, lsb_val};
                end
            end
`endif
        end
        return r;
    endfunction

    assign {q_rdy1, q_val1} = query(q_pos1);
    assign {q_rdy2, q_val2} = query(q_pos2);

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at writeback time and
// a negedge monitor checks every commit pulse against them.
module tb_reorder_buffer;

    logic        clk, rst_n, rdy, issue;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_pred_jmp;
    logic [3:0]  alloc_pos;
    logic        rob_full;
    logic        alu_result;
    logic [3:0]  alu_rob_pos;
    logic [31:0] alu_val;
    logic        alu_real_jmp;
    logic [31:0] alu_jmp_pc;
    logic        lsb_result;
    logic [3:0]  lsb_rob_pos;
    logic [31:0] lsb_val;
    logic [3:0]  q_pos1, q_pos2;
    logic        q_rdy1, q_rdy2;
    logic [31:0] q_val1, q_val2;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;
    logic        commit_store;
    logic        rollback;
    logic [31:0] rollback_pc;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  pos;
        logic        st;
        logic        rb;
        logic [31:0] rbpc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [4:0] exp_rd [16];

    reorder_buffer #(
        .ROB_SIZE    (16),
        .ROB_POS_WID (4),
        .REG_POS_WID (5),
        .DATA_WID    (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .issue          (issue),
        .issue_type     (issue_type),
        .issue_rd       (issue_rd),
        .issue_pc       (issue_pc),
        .issue_pred_jmp (issue_pred_jmp),
        .alloc_pos      (alloc_pos),
        .rob_full       (rob_full),
        .alu_result     (alu_result),
        .alu_rob_pos    (alu_rob_pos),
        .alu_val        (alu_val),
        .alu_real_jmp   (alu_real_jmp),
        .alu_jmp_pc     (alu_jmp_pc),
        .lsb_result     (lsb_result),
        .lsb_rob_pos    (lsb_rob_pos),
        .lsb_val        (lsb_val),
        .q_pos1         (q_pos1),
        .q_pos2         (q_pos2),
        .q_rdy1         (q_rdy1),
        .q_rdy2         (q_rdy2),
        .q_val1         (q_val1),
        .q_val2         (q_val2),
        .commit         (commit),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos),
        .commit_store   (commit_store),
        .rollback       (rollback),
        .rollback_pc    (rollback_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] pos,
                            input logic st, input logic rb, input logic [31:0] rbpc);
        exp_t e;
        e.rd = rd; e.val = val; e.pos = pos; e.st = st; e.rb = rb; e.rbpc = rbpc;
        sb.push_back(e);
    endtask

    task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                               input logic pj);
        issue = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc; issue_pred_jmp = pj;
        tick();
        issue = 1'b0;
    endtask

    task automatic alu_wb(input logic [3:0] pos, input logic [31:0] val, input logic rj,
                          input logic [31:0] jpc);
        alu_result = 1'b1; alu_rob_pos = pos; alu_val = val; alu_real_jmp = rj; alu_jmp_pc = jpc;
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (commit) begin
                if (sb.size() == 0) begin
                    check("spurious_commit", 32'(commit), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("commit_rd", 32'(commit_rd), 32'(e.rd));
                    check("commit_val", commit_val, e.val);
                    check("commit_rob_pos", 32'(commit_rob_pos), 32'(e.pos));
                    check("commit_store", 32'(commit_store), 32'(e.st));
                    check("rollback", 32'(rollback), 32'(e.rb));
                    if (e.rb) check("rollback_pc", rollback_pc, e.rbpc);
                end
            end else if (rollback || commit_store) begin
                check("orphan_pulse", {30'd0, rollback, commit_store}, 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; issue = 1'b0; issue_type = '0; issue_rd = '0; issue_pc = '0;
        issue_pred_jmp = 1'b0; alu_result = 1'b0; alu_rob_pos = '0; alu_val = '0;
        alu_real_jmp = 1'b0; alu_jmp_pc = '0; lsb_result = 1'b0; lsb_rob_pos = '0;
        lsb_val = '0; q_pos1 = '0; q_pos2 = '0;
        #3;
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_rollback", 32'(rollback), 32'd0);
        check("rst_commit_store", 32'(commit_store), 32'd0);
        check("rst_rollback_pc", rollback_pc, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_alloc_pos", 32'(alloc_pos), 32'd0);
        check("rst_rob_full", 32'(rob_full), 32'd0);

        // Single REG instruction.
        drive_issue(2'd0, 5'd5, 32'h10, 1'b0);
        check("t2_alloc_pos", 32'(alloc_pos), 32'd1);
        alu_wb(4'd0, 32'hDEAD, 1'b0, 32'h0);
        q_pos1 = 4'd0;
        push_exp(5'd5, 32'hDEAD, 4'd0, 1'b0, 1'b0, 32'h0);
        tick();
        alu_result = 1'b0;
        check("t2_q_rdy_ready", 32'(q_rdy1), 32'd1);
        check("t2_q_val_ready", q_val1, 32'hDEAD);
        tick();
        check("t2_q_rdy_retired", 32'(q_rdy1), 32'd0);
        check("t2_q_val_retired", q_val1, 32'd0);
        tick();

        // Out-of-order writebacks, in-order retire (pos1, pos2).
        drive_issue(2'd0, 5'd1, 32'h20, 1'b0);
        drive_issue(2'd0, 5'd2, 32'h24, 1'b0);
        alu_wb(4'd2, 32'h22, 1'b0, 32'h0);
        tick();
        alu_result = 1'b0;
        tick(); tick();
        lsb_result = 1'b1; lsb_rob_pos = 4'd1; lsb_val = 32'h11;
        push_exp(5'd1, 32'h11, 4'd1, 1'b0, 1'b0, 32'h0);
        push_exp(5'd2, 32'h22, 4'd2, 1'b0, 1'b0, 32'h0);
        tick();
        lsb_result = 1'b0;
        tick();
        check("t3_commit_first", 32'(commit), 32'd1);
        tick();
        check("t3_commit_second", 32'(commit), 32'd1);
        check("t3_second_pos", 32'(commit_rob_pos), 32'd2);
        tick();
        check("t3_commit_done", 32'(commit), 32'd0);

        // Fill to 16 from head=tail=3, wrapping 15->0.
        for (int k = 0; k < 16; k++) begin
            exp_rd[(3 + k) % 16] = 5'(k + 1);
            drive_issue(2'd0, 5'(k + 1), 32'h1000 + 32'(4 * k), 1'b0);
        end
        check("t4_full", 32'(rob_full), 32'd1);
        check("t4_full_alloc", 32'(alloc_pos), 32'd3);
        drive_issue(2'd0, 5'd31, 32'hFFF0, 1'b0);
        check("t4_17th_alloc", 32'(alloc_pos), 32'd3);
        check("t4_17th_full", 32'(rob_full), 32'd1);
        // Same-tag ALU and LSB writeback: ALU value must win.
        alu_wb(4'd3, 32'h300, 1'b0, 32'h0);
        lsb_result = 1'b1; lsb_rob_pos = 4'd3; lsb_val = 32'hBAD;
        push_exp(exp_rd[3], 32'h300, 4'd3, 1'b0, 1'b0, 32'h0);
        tick();
        alu_result = 1'b0;
        lsb_rob_pos = 4'd4; lsb_val = 32'h400;
        push_exp(exp_rd[4], 32'h400, 4'd4, 1'b0, 1'b0, 32'h0);
        tick();
        lsb_result = 1'b0;
        check("t4_after_retire_full", 32'(rob_full), 32'd0);
        exp_rd[3] = 5'd9;
        drive_issue(2'd0, 5'd9, 32'h2000, 1'b0);
        check("t4_issue_retire_full", 32'(rob_full), 32'd0);
        check("t4_issue_retire_alloc", 32'(alloc_pos), 32'd4);
        exp_rd[4] = 5'd10;
        drive_issue(2'd0, 5'd10, 32'h2004, 1'b0);
        check("t4_refull", 32'(rob_full), 32'd1);
        check("t4_refull_alloc", 32'(alloc_pos), 32'd5);
        for (int j = 0; j < 16; j++) begin
            alu_wb(4'((5 + j) % 16), 32'h5000 + 32'((5 + j) % 16), 1'b0, 32'h0);
            push_exp(exp_rd[(5 + j) % 16], 32'h5000 + 32'((5 + j) % 16), 4'((5 + j) % 16),
                     1'b0, 1'b0, 32'h0);
            tick();
        end
        alu_result = 1'b0;
        tick(); tick(); tick();
        check("t4_drained_full", 32'(rob_full), 32'd0);
        check("t4_drained_alloc", 32'(alloc_pos), 32'd5);

        // Mispredicted taken branch at pos5 with a younger REG at pos6.
        drive_issue(2'd1, 5'd0, 32'h100, 1'b0);
        drive_issue(2'd0, 5'd7, 32'h104, 1'b0);
        alu_wb(4'd5, 32'h104, 1'b1, 32'h200);
        push_exp(5'd0, 32'h104, 4'd5, 1'b0, 1'b1, 32'h200);
        tick();
        alu_result = 1'b0;
        issue = 1'b1; issue_type = 2'd0; issue_rd = 5'd8; issue_pc = 32'h108;
        lsb_result = 1'b1; lsb_rob_pos = 4'd6; lsb_val = 32'h66;
        tick();
        lsb_result = 1'b0;
        check("t5_rollback", 32'(rollback), 32'd1);
        check("t5_flush_alloc", 32'(alloc_pos), 32'd0);
        check("t5_flush_full", 32'(rob_full), 32'd0);
        alu_wb(4'd0, 32'h77, 1'b0, 32'h0);
        tick();
        issue = 1'b0; alu_result = 1'b0;
        q_pos1 = 4'd0; q_pos2 = 4'd6;
        #1;
        check("t5_rb_cycle_issue_dropped", 32'(alloc_pos), 32'd0);
        check("t5_rollback_once", 32'(rollback), 32'd0);
        check("t5_q_pos0_idle", 32'(q_rdy1), 32'd0);
        check("t5_q_pos6_flushed", 32'(q_rdy2), 32'd0);

        // rdy=0 freezes issue, writeback and retire.
        rdy = 1'b0;
        issue = 1'b1; issue_type = 2'd0; issue_rd = 5'd3; issue_pc = 32'h500;
        tick();
        check("rdy0_issue_frozen", 32'(alloc_pos), 32'd0);
        rdy = 1'b1;
        tick();
        issue = 1'b0;
        check("rdy1_issue", 32'(alloc_pos), 32'd1);
        rdy = 1'b0;
        alu_wb(4'd0, 32'h33, 1'b0, 32'h0);
        tick();
        rdy = 1'b1; alu_result = 1'b0;
        #1;
        check("rdy0_wb_frozen", 32'(q_rdy1), 32'd0);
        alu_wb(4'd0, 32'h33, 1'b0, 32'h0);
        push_exp(5'd3, 32'h33, 4'd0, 1'b0, 1'b0, 32'h0);
        tick();
        alu_result = 1'b0;
        rdy = 1'b0;
        tick(); tick();
        check("rdy0_no_commit", 32'(commit), 32'd0);
        rdy = 1'b1;
        tick();
        check("rdy1_commit", 32'(commit), 32'd1);

        // Store, correctly predicted branch, mispredicted not-taken branch.
        drive_issue(2'd2, 5'd0, 32'h300, 1'b0);
        drive_issue(2'd1, 5'd0, 32'h350, 1'b1);
        drive_issue(2'd1, 5'd0, 32'h400, 1'b1);
        lsb_result = 1'b1; lsb_rob_pos = 4'd1; lsb_val = 32'hAA;
        alu_wb(4'd2, 32'h354, 1'b1, 32'h600);
        push_exp(5'd0, 32'hAA, 4'd1, 1'b1, 1'b0, 32'h0);
        push_exp(5'd0, 32'h354, 4'd2, 1'b0, 1'b0, 32'h0);
        tick();
        lsb_result = 1'b0;
        alu_wb(4'd3, 32'h0, 1'b0, 32'h700);
        push_exp(5'd0, 32'h0, 4'd3, 1'b0, 1'b1, 32'h404);
        tick();
        alu_result = 1'b0;
        tick(); tick(); tick(); tick();
        check("br_flush_alloc", 32'(alloc_pos), 32'd0);

        // Asynchronous reset while a commit pulse is out.
        drive_issue(2'd0, 5'd4, 32'h800, 1'b0);
        alu_wb(4'd0, 32'h44, 1'b0, 32'h0);
        tick();
        alu_result = 1'b0;
        tick();
        check("rst_mid_commit_high", 32'(commit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_commit", 32'(commit), 32'd0);
        check("rst_mid_rollback", 32'(rollback), 32'd0);
        check("rst_mid_store", 32'(commit_store), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_alloc", 32'(alloc_pos), 32'd0);
        check("rst_mid_full", 32'(rob_full), 32'd0);

        // Query of an entry written back in the same cycle.
        for (int k = 0; k < 4; k++) drive_issue(2'd0, 5'(k + 1), 32'h900 + 32'(4 * k), 1'b0);
        q_pos1 = 4'd3;
        alu_wb(4'd3, 32'd7, 1'b0, 32'h0);
        #1;
`ifdef ROB_QUERY_BYPASS_EN
        check("q_same_cycle_rdy", 32'(q_rdy1), 32'd1);
        check("q_same_cycle_val", q_val1, 32'd7);
`else
        check("q_same_cycle_rdy", 32'(q_rdy1), 32'd0);
        check("q_same_cycle_val", q_val1, 32'd0);
`endif
        tick();
        alu_result = 1'b0;
        check("q_next_cycle_rdy", 32'(q_rdy1), 32'd1);
        check("q_next_cycle_val", q_val1, 32'd7);
        tick(); tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
